// File: rtl/smm_job_sched_if.sv
// smm_job_sched_if: job-side and result-side handshakes of the Strassen job
// sequencer.
//
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid and ready are both high. The source holds valid and its
// payload steady until that edge. Ready may depend on nothing but the sink's
// own state (plus flush on the scheduler's in_ready).
//
//   in_valid / in_ready   job offer and acceptance
//   in_a, in_b            operand matrices (BUSWIDTH bits each)
//   in_sel                datapath mode for the job
//   in_tag                job tag, returned with the result
//   out_valid / out_ready result offer and acceptance
//   out_c                 captured product
//   out_tag               tag of the job that produced out_c
//
// Modport master is the job producer / result consumer. Modport slave is
// the scheduler.
interface smm_job_sched_if #(
    parameter int BUSWIDTH = 512,
    parameter int TAGW     = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [BUSWIDTH-1:0] in_a;
    logic [BUSWIDTH-1:0] in_b;
    logic                in_sel;
    logic [TAGW-1:0]     in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [BUSWIDTH-1:0] out_c;
    logic [TAGW-1:0]     out_tag;

    modport master (
        output in_valid, in_a, in_b, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_tag
    );
endinterface

// File: rtl/smm_job_sched.sv
// smm_job_sched: one-job-at-a-time sequencer for the 4x4 Strassen datapath.
//
// The scheduler works through these steps for each job:
//   1. Accepts a job over job.in_*.
//   2. Registers the operands, mode and tag.
//   3. Pulses smm_load for one cycle.
//   4. Waits LATENCY cycles.
//   5. Captures smm_c.
//   6. Offers the result on job.out_*.
// Only one job is in flight at a time, because smm_sel steers the
// datapath's combinational output stage.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   job           smm_job_sched_if.slave (job and result handshakes)
//   flush         synchronous abort. It returns to IDLE from any busy
//                 state and blocks acceptance while in IDLE.
//   smm_load      one-cycle load strobe to the datapath
//   smm_sel       datapath mode, held for the whole job
//   smm_a, smm_b  registered operands to the datapath
//   smm_c         datapath product
//   busy          high in every state except IDLE (registered decode)
//   job_count     completed-job counter, saturating at 16'hFFFF
//   dbg_state     current FSM state, for checkers
module smm_job_sched #(
    parameter int          DATAWIDTH       = 32,
    parameter int          BUSWIDTH        = DATAWIDTH * 16,
    parameter int          LATENCY         = 6,
    parameter int          TAGW            = 4,
    // Reset value of job_count. It is nonzero only in builds that exercise
    // saturation without running 65k jobs.
    parameter logic [15:0] JOB_COUNT_RESET = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    smm_job_sched_if.slave      job,
    input  logic                flush,
    output logic                smm_load,
    output logic                smm_sel,
    output logic [BUSWIDTH-1:0] smm_a,
    output logic [BUSWIDTH-1:0] smm_b,
    input  logic [BUSWIDTH-1:0] smm_c,
    output logic                busy,
    output logic [15:0]         job_count,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] WAIT_LOAD = 8'(LATENCY - 1);

    logic [1:0]          state;
    logic [7:0]          wait_cnt;
    logic [TAGW-1:0]     tag_q;
    logic [BUSWIDTH-1:0] out_c_q;
    logic [TAGW-1:0]     out_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            smm_sel   <= 1'b0;
            smm_a     <= '0;
            smm_b     <= '0;
            tag_q     <= '0;
            out_c_q   <= '0;
            out_tag_q <= '0;
            job_count <= JOB_COUNT_RESET;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job.in_valid && !flush) begin
                        smm_a   <= job.in_a;
                        smm_b   <= job.in_b;
                        smm_sel <= job.in_sel;
                        tag_q   <= job.in_tag;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (wait_cnt != 8'd0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end else begin
                        // The datapath output is valid on this edge:
                        // LATENCY edges after the load cycle closed.
                        out_c_q   <= smm_c;
                        out_tag_q <= tag_q;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (job.out_ready) begin
                        state <= S_IDLE;
                        if (job_count != 16'hFFFF) begin
                            job_count <= job_count + 16'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // in_ready is held low while rst is high. Apart from rst, its only
    // combinational input is flush.
    assign job.in_ready  = (state == S_IDLE) && !flush && !rst;
    assign job.out_valid = (state == S_DONE);
    assign job.out_c     = out_c_q;
    assign job.out_tag   = out_tag_q;
    assign smm_load      = (state == S_ISSUE);
    assign busy          = (state != S_IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_smm_job_sched.sv
module tb_smm_job_sched;

    localparam int DW   = 32;
    localparam int BW   = DW * 16;
    localparam int TAGW = 4;
    localparam int LAT  = 6;
    localparam int W    = BW + TAGW;

    localparam logic [1:0] S_IDLE = 2'd0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT under test (LATENCY=6) ----------------
    smm_job_sched_if #(.BUSWIDTH(BW), .TAGW(TAGW)) job ();
    logic          flush;
    logic          smm_load, smm_sel, busy;
    logic [BW-1:0] smm_a, smm_b, smm_c;
    logic [15:0]   job_count;
    logic [1:0]    dbg_state;

    smm_job_sched #(.DATAWIDTH(DW), .BUSWIDTH(BW), .LATENCY(LAT), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .job(job), .flush(flush),
        .smm_load(smm_load), .smm_sel(smm_sel), .smm_a(smm_a), .smm_b(smm_b),
        .smm_c(smm_c), .busy(busy), .job_count(job_count), .dbg_state(dbg_state)
    );

    // ---------------- saturation build (LATENCY=1, count preloaded) ----------------
    smm_job_sched_if #(.BUSWIDTH(BW), .TAGW(TAGW)) job2 ();
    logic          flush2;
    logic          smm_load2, smm_sel2, busy2;
    logic [BW-1:0] smm_a2, smm_b2, smm_c2;
    logic [15:0]   job_count2;
    logic [1:0]    dbg_state2;

    smm_job_sched #(.DATAWIDTH(DW), .BUSWIDTH(BW), .LATENCY(1), .TAGW(TAGW),
                    .JOB_COUNT_RESET(16'hFFFE)) dut_sat (
        .clk(clk), .rst(rst), .job(job2), .flush(flush2),
        .smm_load(smm_load2), .smm_sel(smm_sel2), .smm_a(smm_a2), .smm_b(smm_b2),
        .smm_c(smm_c2), .busy(busy2), .job_count(job_count2), .dbg_state(dbg_state2)
    );
    assign smm_c2 = '0;

    // ---------------- matrix helpers ----------------
    function automatic logic [BW-1:0] mat_seq(input int base);
        logic [BW-1:0] m;
        for (int k = 0; k < 16; k++) m[k*DW +: DW] = DW'(base + k);
        return m;
    endfunction

    function automatic logic [BW-1:0] mat_ident();
        logic [BW-1:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) m[(k*5)*DW +: DW] = 32'd1;
        return m;
    endfunction

    // sel=0: A*B, sel=1: B*A (row-major, element (r,c) at index r*4+c)
    function automatic logic [BW-1:0] mat_mul(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                              input logic sel);
        logic [BW-1:0] x, y, m;
        logic [DW-1:0] acc;
        x = sel ? b : a;
        y = sel ? a : b;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) acc = acc + x[(r*4+k)*DW +: DW] * y[(k*4+c)*DW +: DW];
                m[(r*4+c)*DW +: DW] = acc;
            end
        end
        return m;
    endfunction

    // ---------------- datapath stand-in ----------------
    // Product is only presented once LAT edges have passed since the load
    // cycle closed; before that it drives a poison pattern.
    int dp_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) dp_cnt <= 0;
        else if (smm_load) dp_cnt <= 1;
        else if (dp_cnt != 0 && dp_cnt < 255) dp_cnt <= dp_cnt + 1;
    end
    always_comb begin
        smm_c = {16{32'hBADC0DE5}};
        if (dp_cnt >= LAT) smm_c = mat_mul(smm_a, smm_b, smm_sel);
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: a result transfers on the edge after a negedge that sees
    // out_valid && out_ready with no flush.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && job.out_valid && job.out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected observed tag=%0h expected none", job.out_tag);
            end else begin
                e = exp_q.pop_front();
                check("sb_out_c", job.out_c, e[BW-1:0]);
                check("sb_out_tag", BW'(job.out_tag), BW'(e[BW +: TAGW]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_job(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sel,
                             input logic [TAGW-1:0] tag, input bit push);
        job.in_a     = a;
        job.in_b     = b;
        job.in_sel   = sel;
        job.in_tag   = tag;
        job.in_valid = 1'b1;
        if (push) exp_q.push_back({tag, mat_mul(a, b, sel)});
    endtask

    // Offer a job from IDLE, take the accept edge, drop in_valid.
    task automatic accept_job(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sel,
                              input logic [TAGW-1:0] tag, input bit push);
        drive_job(a, b, sel, tag, push);
        tick();
        job.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max);
        int n = 0;
        while (!job.out_valid && n < max) begin
            tick();
            n++;
        end
        check("out_valid_timeout", BW'(job.out_valid), BW'(1));
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        check("idle_timeout", BW'(busy), BW'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, BW'(job.in_ready), BW'(0));
        check({tag, "_busy"}, BW'(busy), BW'(0));
        check({tag, "_load_sel_valid"}, BW'({smm_load, smm_sel, job.out_valid}), BW'(0));
        check({tag, "_smm_a"}, smm_a, '0);
        check({tag, "_smm_b"}, smm_b, '0);
        check({tag, "_out_c"}, job.out_c, '0);
        check({tag, "_out_tag"}, BW'(job.out_tag), BW'(0));
        check({tag, "_job_count"}, BW'(job_count), BW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int acc_cyc[3];
    logic       b2b_sel[3];
    logic [BW-1:0] bp_exp;

    initial begin
        job.in_valid = 1'b0; job.in_a = '0; job.in_b = '0; job.in_sel = 1'b0; job.in_tag = '0;
        job.out_ready = 1'b1;
        flush = 1'b0;
        job2.in_valid = 1'b0; job2.in_a = '0; job2.in_b = '0; job2.in_sel = 1'b0; job2.in_tag = '0;
        job2.out_ready = 1'b1;
        flush2 = 1'b0;

        // Reset values.
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", BW'(job.in_ready), BW'(1));
        tick();

        // Single job: I * (1..16) = 1..16, tag 5.
        accept_job(mat_ident(), mat_seq(1), 1'b0, 4'd5, 1'b1);
        check("single_issue_load", BW'(smm_load), BW'(1));
        check("single_smm_a", smm_a, mat_ident());
        check("single_smm_b", smm_b, mat_seq(1));
        check("single_issue_in_ready", BW'(job.in_ready), BW'(0));
        for (int i = 1; i <= LAT; i++) begin
            tick();
            check("single_wait_load_valid", BW'({smm_load, job.out_valid}), BW'(0));
        end
        tick();
        check("single_out_valid_e7", BW'(job.out_valid), BW'(1));
        check("single_out_c", job.out_c, mat_seq(1));
        tick();
        check("single_job_count", BW'(job_count), BW'(1));
        check("single_idle_in_ready", BW'(job.in_ready), BW'(1));

        // Backpressure: hold out_ready low for 10 cycles.
        job.out_ready = 1'b0;
        bp_exp = mat_mul(mat_seq(1), mat_seq(17), 1'b1);
        accept_job(mat_seq(1), mat_seq(17), 1'b1, 4'd9, 1'b1);
        wait_out(20);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", BW'(job.out_valid), BW'(1));
            check("bp_out_c", job.out_c, bp_exp);
            check("bp_out_tag", BW'(job.out_tag), BW'(9));
            check("bp_in_ready", BW'(job.in_ready), BW'(0));
            tick();
        end
        check("bp_count_held", BW'(job_count), BW'(1));
        job.out_ready = 1'b1;
        tick();
        check("bp_released_valid", BW'(job.out_valid), BW'(0));
        check("bp_job_count", BW'(job_count), BW'(2));
        check("bp_in_ready_next", BW'(job.in_ready), BW'(1));
        check("bp_sb_empty", BW'(exp_q.size()), BW'(0));

        // Back-to-back, in_valid held high, tags 1,2,3.
        b2b_sel[0] = 1'b0; b2b_sel[1] = 1'b1; b2b_sel[2] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            int n;
            drive_job(mat_seq(j * 16 + 3), mat_seq(j * 16 + 40), b2b_sel[j], TAGW'(j + 1), 1'b1);
            n = 0;
            while (!job.in_ready && n < 20) begin
                check("b2b_sel_stable", BW'(smm_sel), BW'(b2b_sel[j-1]));
                tick();
                n++;
            end
            check("b2b_ready_timeout", BW'(job.in_ready), BW'(1));
            tick();
            acc_cyc[j] = cyc;
            check("b2b_sel_loaded", BW'(smm_sel), BW'(b2b_sel[j]));
            if (j > 0) check("b2b_spacing", BW'(acc_cyc[j] - acc_cyc[j-1]), BW'(LAT + 3));
        end
        job.in_valid = 1'b0;
        wait_idle(20);
        check("b2b_job_count", BW'(job_count), BW'(5));
        check("b2b_sb_empty", BW'(exp_q.size()), BW'(0));

        // Flush in ISSUE.
        accept_job(mat_seq(100), mat_seq(200), 1'b1, 4'd7, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_issue_state", BW'(dbg_state), BW'(S_IDLE));
        check("flush_issue_count", BW'(job_count), BW'(5));
        check("flush_issue_smm_a_kept", smm_a, mat_seq(100));
        check("flush_issue_smm_sel_kept", BW'(smm_sel), BW'(1));

        // Flush in WAIT with counter at 3.
        accept_job(mat_seq(300), mat_seq(400), 1'b0, 4'd8, 1'b0);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_wait_state", BW'(dbg_state), BW'(S_IDLE));
        check("flush_wait_valid", BW'(job.out_valid), BW'(0));
        check("flush_wait_count", BW'(job_count), BW'(5));

        // Flush in DONE.
        job.out_ready = 1'b0;
        accept_job(mat_seq(500), mat_seq(600), 1'b0, 4'd10, 1'b0);
        wait_out(20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        job.out_ready = 1'b1;
        check("flush_done_state", BW'(dbg_state), BW'(S_IDLE));
        check("flush_done_valid", BW'(job.out_valid), BW'(0));
        check("flush_done_count", BW'(job_count), BW'(5));

        // Flush together with in_valid in IDLE: no accept.
        drive_job(mat_seq(700), mat_seq(800), 1'b1, 4'd11, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_idle_in_ready", BW'(job.in_ready), BW'(0));
        tick();
        job.in_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle_no_accept", BW'(busy), BW'(0));
        check("flush_idle_smm_a_kept", smm_a, mat_seq(500));

        // Asynchronous reset mid-WAIT, between clock edges.
        accept_job(mat_seq(900), mat_seq(1000), 1'b1, 4'd12, 1'b0);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        rst = 1'b0;
        tick();
        accept_job(mat_ident(), mat_seq(50), 1'b0, 4'd6, 1'b1);
        wait_out(20);
        tick();
        check("arst_job_count", BW'(job_count), BW'(1));
        check("arst_sb_empty", BW'(exp_q.size()), BW'(0));

        // Saturation on the preloaded LATENCY=1 build.
        check("sat_reset_value", BW'(job_count2), BW'(16'hFFFE));
        for (int j = 0; j < 3; j++) begin
            job2.in_valid = 1'b1;
            tick();
            job2.in_valid = 1'b0;
            check("sat_issue_load", BW'(smm_load2), BW'(1));
            tick();
            check("sat_wait_valid", BW'(job2.out_valid), BW'(0));
            tick();
            check("sat_done_valid", BW'(job2.out_valid), BW'(1));
            tick();
            check("sat_count", BW'(job_count2), BW'(16'hFFFF));
            check("sat_idle", BW'(busy2), BW'(0));
        end

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/smm_job_sched.md
# smm_job_sched

Job sequencer for the 4x4 Strassen matrix-multiply datapath (the level-1 block built from seven level-0 multipliers). It accepts operand-pair jobs over a valid/ready handshake, registers them, and drives the datapath's `load` pulse and `sel` mode. It holds operands and mode stable for the datapath's fixed latency, captures the product, and returns it over a second valid/ready handshake. Exactly one job is in flight at a time, because `sel` steers the datapath's combinational output stage and must not change mid-job.

## Interface
Parameters:
- `DATAWIDTH`, 32, element width in bits
- `BUSWIDTH`, `DATAWIDTH*16`, full 4x4 matrix bus width
- `LATENCY`, 6, cycles from the `smm_load` cycle's closing edge to valid `smm_c`; legal range 1..255
- `TAGW`, 4, job tag width

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous active-high reset
- `in_valid`  in  1  job offered
- `in_ready`  out  1  scheduler can accept a job
- `in_a`, `in_b`  in  BUSWIDTH  operand matrices
- `in_sel`  in  1  datapath mode for this job
- `in_tag`  in  TAGW  job tag, returned with result
- `flush`  in  1  synchronous abort of current job
- `smm_load`  out  1  load strobe to datapath
- `smm_sel`  out  1  mode to datapath
- `smm_a`, `smm_b`  out  BUSWIDTH  registered operands to datapath
- `smm_c`  in  BUSWIDTH  datapath product
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `out_c`  out  BUSWIDTH  captured product
- `out_tag`  out  TAGW  tag of the captured job
- `busy`  out  1  high in every state except IDLE
- `job_count`  out  16  completed-job counter, saturating

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Encoding is free.
- IDLE: `in_ready=1`. On `in_valid&&in_ready`, register `in_a`, `in_b`, `in_sel` and `in_tag` into `smm_a`, `smm_b`, `smm_sel` and the tag register, then go to ISSUE.
- ISSUE: `smm_load=1` for exactly this one cycle. Load the wait counter with LATENCY-1, then go to WAIT.
- WAIT: `smm_load=0`. If counter≠0, decrement it. If counter==0, capture `smm_c` into `out_c` at that edge and go to DONE.
- DONE: `out_valid=1`. On `out_ready`, go to IDLE and increment `job_count`; `job_count` saturates at 16'hFFFF and never wraps.
- `smm_a`, `smm_b`, `smm_sel` and the tag register change only on an accept edge. They stay stable from ISSUE through DONE.
- `out_c` and `out_tag` change only on the capture edge. They stay stable while `out_valid` is high.
- `flush` in any non-IDLE state forces IDLE at the next edge:
  - `out_valid` drops.
  - `job_count` does not increment.
  - `smm_*` operand registers keep their values.
- `flush` in IDLE blocks acceptance: with `in_valid` and `flush` high together, no job is taken. `in_ready` is `IDLE && !flush`.
- `out_ready` asserted outside DONE has no effect.
- Reset (asserted at any time, including mid-job) forces:
  - state IDLE, counter 0
  - `smm_load=0`, `smm_sel=0`
  - `smm_a`, `smm_b`, `out_c`, `out_tag`, `job_count` = 0
  - `out_valid=0`, `busy=0`
- `in_ready` reads 0 while `rst` is high and 1 on the first cycle after deassertion.

## Timing
- Accept at edge E0. ISSUE occupies cycle E0–E1 with `smm_load=1`.
- WAIT occupies LATENCY cycles. Capture happens at edge E(1+LATENCY).
- `out_valid` is first high after E(1+LATENCY): with LATENCY=6, accept at E0 gives capture at E7.
- `out_valid` and `out_ready` both high at edge En: the state is IDLE after En, and the next accept is possible at En+1.
- Minimum job period with a consumer that is always ready: LATENCY+3 cycles.
- `busy` is registered state decode, with no combinational path from inputs.
- `in_ready` has one combinational input path: `flush`.
- No other output depends combinationally on any input.

## Test plan
- Reset then single job: identity in `in_a`, matrix 1..16 in `in_b`, `in_sel=0`, tag 5, LATENCY=6, `out_ready=1`.
  - `smm_load` high only in cycle E0–E1.
  - `out_valid` rises after E7 with `out_c`=1..16 and tag 5.
  - `job_count=1`.
- Backpressure: hold `out_ready=0` for 10 cycles after `out_valid`.
  - `out_valid`, `out_c` and `out_tag` stay constant; `in_ready=0` throughout.
  - Release: one transfer, `job_count` increments once.
  - `in_ready=1` on the next cycle.
- Back-to-back jobs with tags 1, 2, 3, `in_valid` held high and `out_ready=1`:
  - accepts spaced exactly 9 cycles apart;
  - outputs in order 1, 2, 3;
  - `smm_sel` follows each job's `in_sel` and does not change mid-job.
- `flush` in each of ISSUE, WAIT (counter=3) and DONE:
  - state is IDLE next cycle and `out_valid=0`;
  - `job_count` unchanged.
  - `flush` together with `in_valid` in IDLE: no accept.
- Asynchronous reset pulsed mid-WAIT, between clock edges:
  - all outputs reach their reset values immediately, without waiting for a clock edge;
  - the first job after release completes normally with `job_count=1`.
- Saturation: preload to 16'hFFFE via 2 jobs on a `job_count` bench-forced build, or run 65 537 jobs at LATENCY=1 → count holds at 16'hFFFF.
